// File: rtl/cpu_types_pkg.sv
// Basic datapath types shared by CPU-side blocks.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/dcache_pkg.sv
// Data cache controller state encoding.
package dcache_pkg;
  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, CNT, DONE} dcache_state_t;
endpackage

// File: rtl/dcache_way.sv
// One cache way: tag/valid/dirty/data storage, combinational read, single-index write port.
module dcache_way
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WORDS = 2,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WOFF_W = $clog2(WORDS),
  localparam int TAG_W  = 30 - IDX_W - WOFF_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WOFF_W-1:0] woff,
  output logic [TAG_W-1:0]  tag,
  output logic              valid,
  output logic              dirty,
  output logic [31:0]       rdata,
  input  logic              data_we,
  input  logic [31:0]       wdata,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wtag,
  input  logic              valid_we,
  input  logic              valid_val,
  input  logic              dirty_we,
  input  logic              dirty_val,
  input  logic              inval_all
);
  word_t             data_mem [SETS*WORDS];
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [SETS-1:0]   valid_bits;
  logic [SETS-1:0]   dirty_bits;

  assign tag   = tag_mem[idx];
  assign valid = valid_bits[idx];
  assign dirty = dirty_bits[idx];
  assign rdata = data_mem[{idx, woff}];

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge CLK) begin
    if (data_we) data_mem[{idx, woff}] <= wdata;
    if (tag_we)  tag_mem[idx] <= wtag;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else begin
      if (inval_all)     valid_bits <= '0;
      else if (valid_we) valid_bits[idx] <= valid_val;
      if (dirty_we)      dirty_bits[idx] <= dirty_val;
    end
  end
endmodule

// File: rtl/wb_dcache.sv
// Two-way set-associative write-back, write-allocate data cache with flush and hit counter.
module wb_dcache
  import cpu_types_pkg::*;
  import dcache_pkg::*;
#(
  parameter int          SETS        = 8,
  parameter int          WORDS       = 2,
  parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WOFF_W = $clog2(WORDS);
  localparam int TAG_W  = 30 - IDX_W - WOFF_W;
  localparam logic [IDX_W-1:0]  LAST_SET  = IDX_W'(SETS - 1);
  localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(WORDS - 1);

  dcache_state_t     state_reg, state_next;
  logic [WOFF_W-1:0] cnt_reg, cnt_next;
  logic              victim_reg, victim_next;
  logic [TAG_W-1:0]  miss_tag_reg, miss_tag_next;
  logic [IDX_W-1:0]  miss_idx_reg, miss_idx_next;
  logic [IDX_W-1:0]  fl_idx_reg, fl_idx_next;
  logic              fl_way_reg, fl_way_next;
  logic [SETS-1:0]   lru_reg, lru_next;
  word_t             hitcount_reg, hitcount_next;
  logic              miss_seen_reg, miss_seen_next;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WOFF_W-1:0] req_woff;
  logic [IDX_W-1:0]  way_idx;
  logic [WOFF_W-1:0] way_woff;
  logic [TAG_W-1:0]  way_tag [2];
  word_t             way_rdata [2];
  logic [1:0]        way_valid, way_dirty;
  logic [1:0]        data_we, tag_we, valid_we, dirty_we;
  word_t             wdata;
  logic [TAG_W-1:0]  wtag;
  logic              valid_val, dirty_val, inval_all;
  logic              hit0, hit1, hit_way, victim, fl_dirty, fl_step;
  logic              unused_bits;

  assign req_tag     = dmemaddr[31 -: TAG_W];
  assign req_idx     = dmemaddr[2 + WOFF_W +: IDX_W];
  assign req_woff    = dmemaddr[2 +: WOFF_W];
  assign unused_bits = ^dmemaddr[1:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      dcache_way #(.SETS(SETS), .WORDS(WORDS)) u_way (
        .CLK(CLK), .RST(RST), .idx(way_idx), .woff(way_woff),
        .tag(way_tag[gi]), .valid(way_valid[gi]), .dirty(way_dirty[gi]), .rdata(way_rdata[gi]),
        .data_we(data_we[gi]), .wdata(wdata), .tag_we(tag_we[gi]), .wtag(wtag),
        .valid_we(valid_we[gi]), .valid_val(valid_val),
        .dirty_we(dirty_we[gi]), .dirty_val(dirty_val), .inval_all(inval_all)
      );
    end
  endgenerate

  assign hit0     = way_valid[0] && (way_tag[0] == req_tag);
  assign hit1     = way_valid[1] && (way_tag[1] == req_tag);
  assign hit_way  = ~hit0;
  // Prefer an empty way before evicting the least recently used one.
  assign victim   = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_reg[req_idx]);
  assign fl_dirty = way_valid[fl_way_reg] && way_dirty[fl_way_reg];

  always_comb begin
    way_idx  = req_idx;
    way_woff = req_woff;
    case (state_reg)
      WB, FILL: begin way_idx = miss_idx_reg; way_woff = cnt_reg; end
      FLUSH:    begin way_idx = fl_idx_reg;   way_woff = cnt_reg; end
      default:  ;
    endcase
  end

  always_comb begin
    state_next = state_reg;     cnt_next = cnt_reg;           victim_next = victim_reg;
    miss_tag_next = miss_tag_reg; miss_idx_next = miss_idx_reg;
    fl_idx_next = fl_idx_reg;   fl_way_next = fl_way_reg;     lru_next = lru_reg;
    hitcount_next = hitcount_reg; miss_seen_next = miss_seen_reg;
    dhit = 1'b0; dmemload = '0; flushed = 1'b0;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    data_we = '0; tag_we = '0; valid_we = '0; dirty_we = '0;
    wdata = dmemstore; wtag = miss_tag_reg; valid_val = 1'b0; dirty_val = 1'b0;
    inval_all = 1'b0; fl_step = 1'b0;
    case (state_reg)
      IDLE: begin
        if (halt) begin
          state_next = FLUSH; fl_idx_next = '0; fl_way_next = 1'b0; cnt_next = '0;
        end else if (dmemREN || dmemWEN) begin
          if (hit0 || hit1) begin
            dhit = 1'b1;
            if (dmemREN) dmemload = way_rdata[hit_way];
            if (dmemWEN) begin
              data_we[hit_way] = 1'b1; dirty_we[hit_way] = 1'b1; dirty_val = 1'b1;
            end
            lru_next[req_idx] = ~hit_way;
            if (miss_seen_reg) miss_seen_next = 1'b0;
            else               hitcount_next = hitcount_reg + 32'd1;
          end else begin
            victim_next = victim; miss_tag_next = req_tag; miss_idx_next = req_idx;
            cnt_next = '0; miss_seen_next = 1'b1;
            if (way_valid[victim] && way_dirty[victim]) state_next = WB;
            else begin
              state_next = FILL; wtag = req_tag;
              tag_we[victim] = 1'b1; valid_we[victim] = 1'b1;
            end
          end
        end
      end
      WB: begin
        dWEN = 1'b1;
        daddr = {way_tag[victim_reg], miss_idx_reg, cnt_reg, 2'b00};
        dstore = way_rdata[victim_reg];
        if (!dwait) begin
          cnt_next = cnt_reg + WOFF_W'(1);
          if (cnt_reg == LAST_WORD) begin
            // Clean the line and install the new tag as an invalid line for the fill.
            dirty_we[victim_reg] = 1'b1; tag_we[victim_reg] = 1'b1; valid_we[victim_reg] = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        dREN = 1'b1;
        daddr = {miss_tag_reg, miss_idx_reg, cnt_reg, 2'b00};
        wdata = dload;
        if (!dwait) begin
          data_we[victim_reg] = 1'b1;
          cnt_next = cnt_reg + WOFF_W'(1);
          if (cnt_reg == LAST_WORD) begin
            valid_we[victim_reg] = 1'b1; valid_val = 1'b1; dirty_we[victim_reg] = 1'b1;
            state_next = IDLE;
          end
        end
      end
      FLUSH: begin
        if (fl_dirty) begin
          dWEN = 1'b1;
          daddr = {way_tag[fl_way_reg], fl_idx_reg, cnt_reg, 2'b00};
          dstore = way_rdata[fl_way_reg];
          if (!dwait) begin
            cnt_next = cnt_reg + WOFF_W'(1);
            if (cnt_reg == LAST_WORD) begin
              dirty_we[fl_way_reg] = 1'b1; fl_step = 1'b1;
            end
          end
        end else begin
          fl_step = 1'b1;
        end
        if (fl_step) begin
          fl_idx_next = fl_idx_reg + IDX_W'(1);
          if (fl_idx_reg == LAST_SET) begin
            if (fl_way_reg) state_next = CNT;
            else            fl_way_next = 1'b1;
          end
        end
      end
      CNT: begin
        dWEN = 1'b1; daddr = HITCNT_ADDR; dstore = hitcount_reg;
        if (!dwait) begin
          inval_all = 1'b1; state_next = DONE;
        end
      end
      DONE:    flushed = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;      cnt_reg <= '0;       victim_reg <= 1'b0;
      miss_tag_reg <= '0;     miss_idx_reg <= '0;  fl_idx_reg <= '0;
      fl_way_reg <= 1'b0;     lru_reg <= '0;       hitcount_reg <= '0;
      miss_seen_reg <= 1'b0;
    end else begin
      state_reg <= state_next;       cnt_reg <= cnt_next;          victim_reg <= victim_next;
      miss_tag_reg <= miss_tag_next; miss_idx_reg <= miss_idx_next; fl_idx_reg <= fl_idx_next;
      fl_way_reg <= fl_way_next;     lru_reg <= lru_next;          hitcount_reg <= hitcount_next;
      miss_seen_reg <= miss_seen_next;
    end
  end
endmodule

// File: tb/tb_wb_dcache.sv
// Self-checking bench for wb_dcache: directed scenarios plus randomized traffic against an LRU-list model.
module tb_wb_dcache;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ren, wen, halt, dhit, flushed, d_ren, d_wen;
  logic [31:0] addr, store, dmemload, d_addr, d_store;
  logic        dwait = 1'b0;
  logic [31:0] dload = 32'd0;

  logic        rst2, halt2, dhit2, flushed2, d_ren2, d_wen2;
  logic [31:0] dmemload2, d_addr2, d_store2;
  logic        zero_bit = 1'b0;
  logic [31:0] zero_word = 32'd0;

  wb_dcache #(.SETS(8), .WORDS(4), .HITCNT_ADDR(32'h3100)) dut (
    .CLK(clk), .RST(rst), .dmemREN(ren), .dmemWEN(wen), .dmemaddr(addr), .dmemstore(store),
    .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed), .dREN(d_ren), .dWEN(d_wen),
    .daddr(d_addr), .dstore(d_store), .dload(dload), .dwait(dwait));

  wb_dcache #(.SETS(2), .WORDS(2), .HITCNT_ADDR(32'h3100)) dut2 (
    .CLK(clk), .RST(rst2), .dmemREN(zero_bit), .dmemWEN(zero_bit), .dmemaddr(zero_word),
    .dmemstore(zero_word), .halt(halt2), .dhit(dhit2), .dmemload(dmemload2), .flushed(flushed2),
    .dREN(d_ren2), .dWEN(d_wen2), .daddr(d_addr2), .dstore(d_store2), .dload(zero_word),
    .dwait(zero_bit));

  int total = 0;
  int bad = 0;
  int lat = 2;
  int wcnt = 2;
  logic prev_wait = 1'b0;
  logic [65:0] prev_out = '0;

  typedef struct {logic we; logic [31:0] a; logic [31:0] d;} xfer_t;
  xfer_t xq[$];
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];

  // LRU-ordered tag list per set: m0 most recent, m1 older.
  logic [31:0] m0 [8];
  logic [31:0] m1 [8];
  int          mcnt [8];

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'd1;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return init_val(a);
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 8; s++) begin m0[s] = '0; m1[s] = '0; mcnt[s] = 0; end
  endfunction

  function automatic logic model_access(input logic [31:0] a);
    int s;
    logic [31:0] t, tmp;
    s = int'(a[6:4]);
    t = a >> 7;
    if (mcnt[s] >= 1 && m0[s] == t) return 1'b1;
    if (mcnt[s] == 2 && m1[s] == t) begin
      tmp = m0[s]; m0[s] = m1[s]; m1[s] = tmp;
      return 1'b1;
    end
    m1[s] = m0[s]; m0[s] = t;
    if (mcnt[s] < 2) mcnt[s]++;
    return 1'b0;
  endfunction

  // Memory responder: decides dwait/dload for the coming edge and logs completed transfers.
  always @(negedge clk) begin
    if (rst) begin
      dwait = 1'b0; wcnt = lat;
    end else if (d_ren || d_wen) begin
      check("one_direction", {65'd0, d_ren && d_wen}, 66'd0);
      if (prev_wait) check("stable_while_wait", {d_ren, d_wen, d_addr, d_store}, prev_out);
      dload = mem_rd(d_addr);
      if (wcnt == 0) begin
        dwait = 1'b0;
        if (d_wen) bmem[d_addr] = d_store;
        xq.push_back('{we: d_wen, a: d_addr, d: (d_wen ? d_store : dload)});
        wcnt = lat;
      end else begin
        dwait = 1'b1; wcnt--;
      end
    end else begin
      dwait = 1'b0; wcnt = lat;
      check("idle_bus_zero", {2'b00, d_addr, d_store}, 66'd0);
    end
    prev_wait = dwait;
    prev_out = {d_ren, d_wen, d_addr, d_store};
  end

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic first_hit, output logic [31:0] rd);
    logic ok;
    @(posedge clk); #1;
    ren = !w; wen = w; addr = a; store = d;
    first_hit = 1'b0; rd = '0; ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      #3;
      if (dhit) begin ok = 1'b1; first_hit = (c == 0); rd = dmemload; end
      @(posedge clk); #1;
    end
    ren = 1'b0; wen = 1'b0;
    check("access_done", {65'd0, ok}, 66'd1);
  endtask

  task automatic do_flush(input logic with_req);
    logic ok;
    @(posedge clk); #1;
    halt = 1'b1; ren = with_req; addr = 32'h0;
    #3;
    check("halt_no_dhit", {65'd0, dhit}, 66'd0);
    ok = 1'b0;
    for (int c = 0; c < 4000 && !ok; c++) begin @(posedge clk); #3; ok = flushed; end
    ren = 1'b0;
    check("flush_done", {65'd0, ok}, 66'd1);
  endtask

  logic        fh, w, exp_hit;
  logic [31:0] rd, a, d;
  int          n, exp_hits;

  initial begin
    rst = 1'b1; rst2 = 1'b1; ren = 1'b0; wen = 1'b0; halt = 1'b0; halt2 = 1'b0;
    addr = '0; store = '0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_dhit", {65'd0, dhit}, 66'd0);
    check("rst_flushed", {65'd0, flushed}, 66'd0);
    check("rst_dren_dwen", {64'd0, d_ren, d_wen}, 66'd0);
    check("rst_daddr_dstore", {2'b00, d_addr, d_store}, 66'd0);
    check("rst_dmemload", {34'd0, dmemload}, 66'd0);
    @(posedge clk); #1;
    rst = 1'b0; rst2 = 1'b0;

    // Small config: cold flush walks 4 clean lines, one cycle each, before the count write.
    halt2 = 1'b1;
    n = 0;
    for (int c = 1; c <= 20 && n == 0; c++) begin @(posedge clk); #3; if (d_wen2) n = c; end
    check("flush_skip_cycles", 66'(n - 1), 66'd4);
    check("cnt_addr_small", {34'd0, d_addr2}, {34'd0, 32'h3100});
    check("cnt_data_small", {34'd0, d_store2}, 66'd0);
    @(posedge clk); #3;
    check("flushed_small", {65'd0, flushed2}, 66'd1);

    // Cold read fills four words from memory, then hits without counting.
    lat = 2; xq.delete();
    access(1'b0, 32'h40, 32'h0, fh, rd);
    check("cold_miss", {65'd0, fh}, 66'd0);
    check("cold_data", {34'd0, rd}, {34'd0, init_val(32'h40)});
    check("cold_nreads", 66'(xq.size()), 66'd4);
    for (int k = 0; k < 4 && k < xq.size(); k++)
      check("cold_read_addr", {1'b0, xq[k].we, xq[k].a, 32'd0}, {2'b00, 32'h40 + 32'(4 * k), 32'd0});

    access(1'b0, 32'h44, 32'h0, fh, rd);
    check("warm_hit", {65'd0, fh}, 66'd1);
    check("warm_data", {34'd0, rd}, {34'd0, init_val(32'h44)});

    access(1'b1, 32'h40, 32'hDEAD, fh, rd);
    rmem[32'h40] = 32'hDEAD;
    check("write_hit", {65'd0, fh}, 66'd1);
    access(1'b0, 32'hC0, 32'h0, fh, rd);
    check("miss_tag1", {65'd0, fh}, 66'd0);
    xq.delete();
    access(1'b0, 32'h140, 32'h0, fh, rd);
    check("miss_tag2", {65'd0, fh}, 66'd0);
    check("miss_tag2_data", {34'd0, rd}, {34'd0, init_val(32'h140)});
    check("evict_nxfers", 66'(xq.size()), 66'd8);
    for (int k = 0; k < 4 && k < xq.size(); k++)
      check("evict_write", {1'b0, xq[k].we, xq[k].a, xq[k].d},
            {2'b01, 32'h40 + 32'(4 * k), ref_rd(32'h40 + 32'(4 * k))});
    for (int k = 4; k < 8 && k < xq.size(); k++)
      check("evict_fill", {1'b0, xq[k].we, xq[k].a, 32'd0}, {2'b00, 32'h140 + 32'(4 * (k - 4)), 32'd0});

    access(1'b1, 32'h144, 32'hBEEF0001, fh, rd);
    rmem[32'h144] = 32'hBEEF0001;
    check("dirty_hit", {65'd0, fh}, 66'd1);
    xq.delete();
    do_flush(1'b1);
    check("flush_nxfers", 66'(xq.size()), 66'd5);
    for (int k = 0; k < 4 && k < xq.size(); k++)
      check("flush_write", {1'b0, xq[k].we, xq[k].a, xq[k].d},
            {2'b01, 32'h140 + 32'(4 * k), ref_rd(32'h140 + 32'(4 * k))});
    if (xq.size() == 5) check("hitcount_write", {1'b0, xq[4].we, xq[4].a, xq[4].d}, {2'b01, 32'h3100, 32'd3});
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #3;
      check("done_hold", {63'd0, flushed, d_ren, d_wen}, {63'd0, 3'b100});
    end
    halt = 1'b0;

    // Reset while the second fill word is outstanding abandons the fill.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    xq.delete();
    @(posedge clk); #1; ren = 1'b1; addr = 32'h40;
    for (int c = 0; c < 100 && xq.size() == 0; c++) begin @(posedge clk); #1; end
    check("fill_in_progress", {65'd0, d_ren}, 66'd1);
    rst = 1'b1; ren = 1'b0;
    @(posedge clk); #3;
    check("rst_abandons_fill", {64'd0, d_ren, d_wen}, 66'd0);
    rst = 1'b0;
    access(1'b0, 32'h40, 32'h0, fh, rd);
    check("reread_misses", {65'd0, fh}, 66'd0);
    check("reread_data", {34'd0, rd}, {34'd0, ref_rd(32'h40)});

    // Randomized traffic from a clean reset against the LRU-list model.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    model_clear(); exp_hits = 0;
    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(3, 0) << 7) | ($urandom_range(7, 0) << 4) | ($urandom_range(3, 0) << 2);
      w = 1'($urandom_range(1, 0));
      d = $urandom;
      lat = $urandom_range(2, 0);
      exp_hit = model_access(a);
      if (exp_hit) exp_hits++;
      access(w, a, d, fh, rd);
      check("rnd_hit", {65'd0, fh}, {65'd0, exp_hit});
      if (!w) check("rnd_read", {34'd0, rd}, {34'd0, ref_rd(a)});
      else rmem[a] = d;
    end
    xq.delete();
    do_flush(1'b0);
    check("rnd_hitcount", {1'b0, (xq.size() > 0 ? xq[xq.size() - 1].we : 1'b0),
                           (xq.size() > 0 ? xq[xq.size() - 1].a : 32'd0),
                           (xq.size() > 0 ? xq[xq.size() - 1].d : 32'd0)},
          {2'b01, 32'h3100, 32'(exp_hits)});
    foreach (rmem[k]) check("mem_coherent", {34'd0, mem_rd(k)}, {34'd0, rmem[k]});
    halt = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
